key_logic_lab: RTL and testbench
================================

# key_logic_lab

Debounced, parametrised successor to the board's key-to-LED logic demo. N_KEY active-low push keys are synchronised and debounced. One key cycles through six reduction logic modes; the remaining keys are operands. The result and current mode drive the four active-low LEDs, and the buzzer emits a timed tone burst on every debounced key press. The block sits at board top level between the raw `key_sw` pins and the `led`/`buzzer` pins.

## Interface
- N_KEY, 4: number of keys. Must be ≥ 2. Key N_KEY-1 is the mode key; keys N_KEY-2..0 are operands.
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles needed to accept a key change (10 ms at 50 MHz). Must be ≥ 1.
- TONE_HALF_CYCLES, 25000: buzzer half-period in clocks (1 kHz at 50 MHz). Must be ≥ 1.
- BURST_CYCLES, 2500000: tone burst length in clocks (50 ms). Must be ≥ 1.
- clk  in  1  single system clock; all state is on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- key_sw  in  N_KEY  raw keys, active-low (0 = pressed), asynchronous to clk.
- led  out  4  active-low LEDs, registered (0 = lit).
- buzzer  out  1  buzzer drive, registered, idle 0.

## Operation
- Synchroniser: each key_sw bit passes through 2 flops, reset to 1 (released). It is then inverted to an active-high `pressed_sync`.
- Debounce, per key:
  - Keeps a stable bit `deb` (reset 0) and a counter (reset 0).
  - When `pressed_sync` equals `deb`, the counter clears.
  - Otherwise the counter increments. On the cycle the counter would reach DEBOUNCE_CYCLES, `deb` takes `pressed_sync` and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles is fully ignored.
- Press event: a one-cycle pulse when `deb` goes 0→1. Releases produce no event.
- Mode register (3 bits, reset 0). It advances on a mode-key press event: 0 XOR, 1 XNOR, 2 AND, 3 OR, 4 NAND, 5 NOR, then wraps 5→0. Values 6–7 are unreachable. If ever present they must behave as mode 0 and wrap to 0 on the next press.
- Result: reduction of the current mode over the operand `deb` bits N_KEY-2..0 (pressed = 1). The mode key is never an operand.
- LEDs, registered every cycle:
  - led[0] = ~result.
  - led[3:1] = ~mode.
- Buzzer:
  - Any press event on any key (mode key included) loads the burst counter with BURST_CYCLES and sets burst active.
  - While active, buzzer toggles every TONE_HALF_CYCLES cycles, and the burst counter decrements once per cycle.
  - At 0 the burst ends and buzzer returns to 0 on that same edge.
  - A press event during a burst reloads the counter (retrigger) without resetting tone phase.
  - When idle, the tone divider is held at 0, so each fresh burst starts with buzzer rising after TONE_HALF_CYCLES cycles.

## Timing
- Reset values (asynchronous, while reset_n = 0): led = 4'b1111, buzzer = 0, mode = 0, all deb = 0, all counters = 0, synchronisers = 1. Since XOR of all-zero operands is 0, led = 4'b1111 is consistent.
- Latency from a clean raw key change to `deb` change is DEBOUNCE_CYCLES + 2 clocks. To led is DEBOUNCE_CYCLES + 3 clocks.
- Mode-key press: the mode updates in the same cycle `deb` rises. led[3:1] and led[0], now evaluated under the new mode, update 1 clock later.
- Buzzer starts toggling TONE_HALF_CYCLES clocks after the press event. It stays toggling for BURST_CYCLES clocks after the last press event.
- Simultaneous events:
  - Mode and operand presses in the same cycle are both taken. The next led value uses the new mode and new operands.
  - Multiple press events in one cycle cause a single reload.
- Reset mid-operation aborts debouncing, bursts and mode immediately. After release, keys held down are re-debounced from scratch, giving a press event after DEBOUNCE_CYCLES + 2 clocks.

## Test plan
Common parameters: N_KEY=4, DEBOUNCE_CYCLES=4, TONE_HALF_CYCLES=2, BURST_CYCLES=16.
- Reset check: hold reset_n=0 with key_sw=4'b0000. Required: led=4'b1111, buzzer=0. After release and 8 clocks, XOR of three pressed operands = 1, so led=4'b1110.
- Bounce rejection: toggle key_sw[0] low for 3 clocks, then high, repeated 5 times. Required: no deb change, led constant at 4'b1111, buzzer stays 0.
- Mode walk: press the mode key (key_sw[3]) 7 times with key_sw[2:0]=3'b110 (only operand 0 pressed). Required led[3:1] sequence ~{1,2,3,4,5,0,1}; led[0] follows XNOR=0→1, AND=0→1, OR=1→0, NAND=1→0, NOR=0→1, XOR=1→0, XNOR=0→1 (led = ~result).
- Latency: clean press of key_sw[0] at edge T. Required: led[0] changes exactly at edge T+7.
- Burst and retrigger:
  - A single press gives buzzer toggling every 2 clocks for 16 clocks, then 0.
  - A second press 10 clocks into the burst extends it to end 16 clocks after the second event, with no phase glitch.
- Reset mid-burst: assert reset_n during toggling. Required: buzzer=0 and led=4'b1111 immediately. After release, mode reads 0.

Source files
------------

// File: rtl/key_logic_lab_if.sv
// key_logic_lab_if: raw key inputs and LED/buzzer outputs of the key logic block.
interface key_logic_lab_if #(parameter int N_KEY = 4);
   logic [N_KEY-1:0] key_sw;
   logic [3:0]       led;
   logic             buzzer;
   modport master (output key_sw, input led, buzzer);
   modport slave (input key_sw, output led, buzzer);
endinterface

// File: rtl/key_logic_lab.sv
// key_logic_lab: debounced keys; one cycles a reduction logic mode, the rest are operands.
// LEDs show mode and result; every press fires a retriggerable buzzer tone burst.
module key_logic_lab #(
   parameter int N_KEY            = 4,
   parameter int DEBOUNCE_CYCLES  = 500000,
   parameter int TONE_HALF_CYCLES = 25000,
   parameter int BURST_CYCLES     = 2500000
) (
   input logic            clk,
   input logic            reset_n,
   key_logic_lab_if.slave bus
);
   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int TW = $clog2(TONE_HALF_CYCLES + 1);
   localparam int BW = $clog2(BURST_CYCLES + 1);
   localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [TW-1:0] T_LAST = TW'(TONE_HALF_CYCLES - 1);
   localparam logic [BW-1:0] B_LOAD = BW'(BURST_CYCLES);
   localparam logic [BW-1:0] B_ONE  = BW'(1);

   logic [N_KEY-1:0] s1, s2, pressed_sync, deb, flip, press;
   logic [N_KEY-2:0] ops;
   logic [2:0]       mode, mode_nxt;
   logic             result, active, any_press, tone_wrap, burst_end;
   logic [TW-1:0]    tone;
   logic [BW-1:0]    burst;

   assign pressed_sync = ~s2;
   assign press        = flip & ~deb;
   assign any_press    = |press;
   assign ops          = deb[N_KEY-2:0];
   assign tone_wrap    = tone == T_LAST;
   assign burst_end    = active && !any_press && burst == B_ONE;

   for (genvar k = 0; k < N_KEY; k++) begin : g_deb
      logic [DW-1:0] cnt;
      always_ff @(posedge clk or negedge reset_n)
         if (!reset_n) cnt <= '0;
         else cnt <= (pressed_sync[k] == deb[k] || cnt == D_LAST) ? '0 : cnt + 1'b1;
      assign flip[k] = pressed_sync[k] != deb[k] && cnt == D_LAST;
   end

   // modes 6-7 are unreachable but decode as XOR and wrap to 0
   always_comb begin
      mode_nxt = mode >= 3'd5 ? 3'd0 : mode + 3'd1;
      result   = mode == 3'd1 ? ~^ops :
                 mode == 3'd2 ?  &ops :
                 mode == 3'd3 ?  |ops :
                 mode == 3'd4 ? ~&ops :
                 mode == 3'd5 ? ~|ops : ^ops;
   end

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         s1      <= '1;
         s2      <= '1;
         deb     <= '0;
         mode    <= '0;
         bus.led <= 4'hf;
      end else begin
         s1      <= bus.key_sw;
         s2      <= s1;
         deb     <= deb ^ flip;
         mode    <= press[N_KEY-1] ? mode_nxt : mode;
         bus.led <= {~mode, ~result};
      end

   // a retrigger reloads the burst length but leaves the tone phase running
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         active     <= 1'b0;
         burst      <= '0;
         tone       <= '0;
         bus.buzzer <= 1'b0;
      end else if (burst_end) begin
         active     <= 1'b0;
         burst      <= '0;
         tone       <= '0;
         bus.buzzer <= 1'b0;
      end else begin
         active     <= active | any_press;
         burst      <= any_press ? B_LOAD : active ? burst - 1'b1 : burst;
         tone       <= !active ? '0 : tone_wrap ? '0 : tone + 1'b1;
         bus.buzzer <= active && tone_wrap ? ~bus.buzzer : bus.buzzer;
      end
endmodule

// File: tb/tb_key_logic_lab.sv
// tb_key_logic_lab: scoreboard bench; expectations are queued at drive time and popped at sampling.
module tb_key_logic_lab;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   n_chk = 0;
   int   n_fail = 0;

   typedef struct {
      string      tag;
      logic [3:0] v;
   } exp_t;
   exp_t sb[$];

   key_logic_lab_if #(.N_KEY(4)) bus ();

   key_logic_lab #(
      .N_KEY(4), .DEBOUNCE_CYCLES(4), .TONE_HALF_CYCLES(2), .BURST_CYCLES(16)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask

   task automatic push(input string tag, input logic [3:0] v);
      sb.push_back('{tag, v});
   endtask

   task automatic pop_chk(input logic [3:0] got);
      exp_t e;
      if (sb.size() == 0) check("sb_underflow", 4'd0, 4'd1);
      else begin
         e = sb.pop_front();
         check(e.tag, got, e.v);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic logic [3:0] tone_at(input int k, input int stop);
      return (k >= 2 && k < stop) ? 4'((k >> 1) & 1) : 4'd0;
   endfunction

   logic [3:0] walk_led [7] = '{4'b1101, 4'b1011, 4'b1000, 4'b0110, 4'b0101, 4'b1110, 4'b1101};

   initial begin
      logic [3:0] prev;
      bus.key_sw = 4'b0000;
      push("rst_led", 4'b1111);
      push("rst_buz", 4'b0000);
      cyc(2);
      pop_chk(bus.led);
      pop_chk({3'b0, bus.buzzer});
      bus.key_sw = 4'b1000;
      cyc(1);
      reset_n = 1'b1;
      push("rst_xor3", 4'b1110);
      cyc(8);
      pop_chk(bus.led);
      bus.key_sw = 4'b1111;
      push("idle_led", 4'b1111);
      push("idle_buz", 4'b0000);
      cyc(30);
      pop_chk(bus.led);
      pop_chk({3'b0, bus.buzzer});

      for (int r = 0; r < 5; r++)
         for (int h = 0; h < 2; h++) begin
            bus.key_sw = h == 0 ? 4'b1110 : 4'b1111;
            for (int c = 0; c < 3; c++) begin
               push("bounce_led", 4'b1111);
               push("bounce_buz", 4'b0000);
               cyc(1);
               pop_chk(bus.led);
               pop_chk({3'b0, bus.buzzer});
            end
         end
      push("bounce_end", 4'b1111);
      cyc(8);
      pop_chk(bus.led);

      bus.key_sw = 4'b1110;
      cyc(10);
      prev = 4'b1110;
      for (int i = 0; i < 7; i++) begin
         bus.key_sw = 4'b0110;
         push("walk_old", prev);
         push("walk_new", walk_led[i]);
         cyc(6);
         pop_chk(bus.led);
         cyc(1);
         pop_chk(bus.led);
         prev = walk_led[i];
         cyc(2);
         bus.key_sw = 4'b1110;
         cyc(8);
      end

      bus.key_sw = 4'b1111;
      push("lat_base", 4'b1100);
      cyc(10);
      pop_chk(bus.led);
      bus.key_sw = 4'b1110;
      push("lat_t6", 4'b1100);
      push("lat_t7", 4'b1101);
      cyc(6);
      pop_chk(bus.led);
      cyc(1);
      pop_chk(bus.led);
      bus.key_sw = 4'b1111;
      cyc(30);

      bus.key_sw = 4'b1101;
      for (int c = 1; c <= 26; c++) push("burst", tone_at(c - 6, 16));
      for (int c = 1; c <= 26; c++) begin
         cyc(1);
         pop_chk({3'b0, bus.buzzer});
      end
      bus.key_sw = 4'b1111;
      cyc(30);

      bus.key_sw = 4'b1101;
      for (int c = 1; c <= 36; c++) push("retrig", tone_at(c - 6, 26));
      for (int c = 1; c <= 36; c++) begin
         cyc(1);
         pop_chk({3'b0, bus.buzzer});
         if (c == 10) bus.key_sw = 4'b1001;
      end
      bus.key_sw = 4'b1111;
      cyc(30);

      bus.key_sw = 4'b1100;
      push("mid_tone", 4'b0001);
      cyc(9);
      pop_chk({3'b0, bus.buzzer});
      reset_n = 1'b0;
      bus.key_sw = 4'b1110;
      push("mid_rst_buz", 4'b0000);
      push("mid_rst_led", 4'b1111);
      #1;
      pop_chk({3'b0, bus.buzzer});
      pop_chk(bus.led);
      cyc(2);
      reset_n = 1'b1;
      push("rel_t6", 4'b1111);
      push("rel_t7", 4'b1110);
      cyc(6);
      pop_chk(bus.led);
      cyc(1);
      pop_chk(bus.led);

      check("sb_drained", 4'(sb.size()), 4'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
